// File: rtl/riscv_pkg.sv
// Shared RV32I encoder/decoder types: format codes, opcodes, field bundle.
// Used by riscv_instr_encoder and the decoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_UNKNOWN = 3'd0,
    FMT_R       = 3'd1,
    FMT_I       = 3'd2,
    FMT_S       = 3'd3,
    FMT_B       = 3'd4,
    FMT_U       = 3'd5,
    FMT_J       = 3'd6,
    FMT_SYSTEM  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_fields_t;

endpackage

// File: rtl/riscv_instr_encoder_if.sv
// Valid/ready field-bundle input and encoded-word output of the encoder.
// master drives bundles and out_ready; slave is the encoder.
interface riscv_instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_type, in_opcode, in_rd,
    output in_funct3, in_rs1, in_rs2, in_funct7,
    output in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_type, in_opcode, in_rd,
    input  in_funct3, in_rs1, in_rs2, in_funct7,
    input  in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

endinterface

// File: rtl/riscv_imm_pack.sv
// Places immediate/funct7 bits per format; flags misaligned and, with
// ENCODER_RANGE_CHECK_EN defined, immediates that overflow their field.
module riscv_imm_pack
  import riscv_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [2:0]  funct3,
  input  logic [6:0]  opcode,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] imm_word,
  output logic        range_err,
  output logic        misaligned
);

  logic is_shift;

  assign is_shift = (fmt == FMT_I) && (opcode == OP_IMM)
                 && (funct3 == 3'd1 || funct3 == 3'd5);

  assign misaligned = (fmt == FMT_B || fmt == FMT_J) && imm[0];

  always_comb begin
    imm_word = '0;
    unique case (fmt)
      FMT_R:
        imm_word = {funct7, 25'd0};
      FMT_I, FMT_SYSTEM:
        if (is_shift) imm_word = {funct7, imm[4:0], 20'd0};
        else          imm_word = {imm[11:0], 20'd0};
      FMT_S:
        imm_word = {imm[11:5], 13'd0, imm[4:0], 7'd0};
      FMT_B:
        imm_word = {imm[12], imm[10:5], 13'd0,
                    imm[4:1], imm[11], 7'd0};
      FMT_U:
        imm_word = {imm[31:12], 12'd0};
      FMT_J:
        imm_word = {imm[20], imm[10:1], imm[11],
                    imm[19:12], 12'd0};
      default:
        imm_word = '0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic fit12, fit13, fit21;

  // sign-extension fits: all bits above the field agree
  assign fit12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fit13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fit21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    range_err = 1'b0;
    unique case (fmt)
      FMT_I, FMT_SYSTEM:
        range_err = is_shift ? (|imm[31:5]) : !fit12;
      FMT_S:   range_err = !fit12;
      FMT_B:   range_err = !fit13;
      FMT_J:   range_err = !fit21;
      FMT_U:   range_err = |imm[11:0];
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/riscv_instr_encoder.sv
// Two-stage valid/ready RV32I encoder: S1 holds fields, S2 the packed word.
// Optional immediate range errors via ENCODER_RANGE_CHECK_EN.
module riscv_instr_encoder
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  riscv_instr_encoder_if.slave bus,
  output logic [CNT_W-1:0] enc_count
);

  enc_fields_t s1;
  logic        s1_valid;
  logic        s2_valid;
  logic        s2_load;
  logic [31:0] s2_instr;
  logic        s2_err;
  logic [31:0] imm_word;
  logic [31:0] packed_w;
  logic        range_err;
  logic        misaligned;
  logic        err_c;
  logic        use_rd, use_rs1, use_rs2;

  assign s2_load       = !s2_valid || bus.out_ready;
  assign bus.in_ready  = !s1_valid || s2_load;
  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_instr;
  assign bus.out_err   = s2_err;

  riscv_imm_pack u_imm_pack (
    .fmt        (s1.fmt),
    .funct3     (s1.funct3),
    .opcode     (s1.opcode),
    .funct7     (s1.funct7),
    .imm        (s1.imm),
    .imm_word   (imm_word),
    .range_err  (range_err),
    .misaligned (misaligned)
  );

  assign use_rd  = s1.fmt inside {FMT_R, FMT_I, FMT_U,
                                  FMT_J, FMT_SYSTEM};
  assign use_rs1 = s1.fmt inside {FMT_R, FMT_I, FMT_S,
                                  FMT_B, FMT_SYSTEM};
  assign use_rs2 = s1.fmt inside {FMT_R, FMT_S, FMT_B};

  // rs1 and funct3 appear in exactly the same formats
  always_comb begin
    packed_w      = imm_word;
    packed_w[6:0] = s1.opcode;
    if (use_rd)  packed_w[11:7]  = s1.rd;
    if (use_rs1) packed_w[14:12] = s1.funct3;
    if (use_rs1) packed_w[19:15] = s1.rs1;
    if (use_rs2) packed_w[24:20] = s1.rs2;
    if (s1.fmt == FMT_UNKNOWN) packed_w = '0;
  end

  assign err_c = (s1.fmt == FMT_UNKNOWN) || misaligned || range_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      s2_valid  <= 1'b0;
      s2_instr  <= '0;
      s2_err    <= 1'b0;
      enc_count <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1 <= '{fmt:    fmt_e'(bus.in_type),
                  opcode: bus.in_opcode,
                  rd:     bus.in_rd,
                  funct3: bus.in_funct3,
                  rs1:    bus.in_rs1,
                  rs2:    bus.in_rs2,
                  funct7: bus.in_funct7,
                  imm:    bus.in_imm};
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= packed_w;
          s2_err   <= err_c;
        end
      end
      if (s2_valid && bus.out_ready)
        enc_count <= enc_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Self-checking bench for riscv_instr_encoder: directed vector table,
// backpressure and reset sequences, randomized stream vs reference model.
module tb_riscv_instr_encoder;

`ifdef ENCODER_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]  typ;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    string       name;
    bundle_t     b;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] enc_count;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  riscv_instr_encoder_if bus ();

  riscv_instr_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .enc_count (enc_count)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v,
                                      input int lo, input int wd);
    return (v >> lo) & ((32'd1 << wd) - 32'd1);
  endfunction

  function automatic logic [31:0] put(input logic [31:0] v,
                                      input int lo);
    return v << lo;
  endfunction

  // Reference: {err, instr} from the format rules, using signed ranges
  function automatic logic [32:0] ref_enc(input bundle_t b);
    logic [31:0] w;
    logic [31:0] i;
    longint      s;
    bit          err;
    bit          oor;
    bit          shift;
    i = b.imm;
    s = longint'($signed(b.imm));
    w = 0;
    err = 0;
    oor = 0;
    shift = (b.typ == 3'd2) && (b.op == 7'h13)
         && (b.f3 == 3'd1 || b.f3 == 3'd5);
    case (b.typ)
      3'd1: w = put(b.f7, 25) | put(b.rs2, 20) | put(b.rs1, 15)
              | put(b.f3, 12) | put(b.rd, 7);
      3'd2, 3'd7: begin
        if (shift) begin
          w = put(b.f7, 25) | put(fld(i, 0, 5), 20);
          oor = i > 32'd31;
        end else begin
          w = put(fld(i, 0, 12), 20);
          oor = s < -2048 || s > 2047;
        end
        w |= put(b.rs1, 15) | put(b.f3, 12) | put(b.rd, 7);
      end
      3'd3: begin
        w = put(fld(i, 5, 7), 25) | put(b.rs2, 20) | put(b.rs1, 15)
          | put(b.f3, 12) | put(fld(i, 0, 5), 7);
        oor = s < -2048 || s > 2047;
      end
      3'd4: begin
        w = put(fld(i, 12, 1), 31) | put(fld(i, 5, 6), 25)
          | put(b.rs2, 20) | put(b.rs1, 15) | put(b.f3, 12)
          | put(fld(i, 1, 4), 8) | put(fld(i, 11, 1), 7);
        err = i[0];
        oor = s < -4096 || s > 4095;
      end
      3'd5: begin
        w = put(fld(i, 12, 20), 12) | put(b.rd, 7);
        oor = fld(i, 0, 12) != 0;
      end
      3'd6: begin
        w = put(fld(i, 20, 1), 31) | put(fld(i, 1, 10), 21)
          | put(fld(i, 11, 1), 20) | put(fld(i, 12, 8), 12)
          | put(b.rd, 7);
        err = i[0];
        oor = s < -(64'sd1 << 20) || s >= (64'sd1 << 20);
      end
      default: err = 1;
    endcase
    if (b.typ != 3'd0) w |= put(b.op, 0);
    err = err | (RANGE_EN && oor);
    return {err, w};
  endfunction

  function automatic bundle_t mk(input logic [2:0] typ,
      input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [6:0] f7, input logic [31:0] imm);
    bundle_t b;
    b.typ = typ; b.op = op; b.rd = rd; b.f3 = f3;
    b.rs1 = rs1; b.rs2 = rs2; b.f7 = f7; b.imm = imm;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int      m;
    b.typ = 3'($urandom_range(7));
    b.rd  = 5'($urandom);
    b.f3  = 3'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    b.f7  = 7'($urandom);
    case (b.typ)
      3'd1: b.op = 7'h33;
      3'd2: b.op = ($urandom_range(1) == 0) ? 7'h13 : 7'h03;
      3'd3: b.op = 7'h23;
      3'd4: b.op = 7'h63;
      3'd5: b.op = 7'h37;
      3'd6: b.op = 7'h6F;
      3'd7: b.op = 7'h73;
      default: b.op = 7'($urandom);
    endcase
    m = $urandom_range(3);
    if (m == 0)      b.imm = $urandom;
    else if (m == 1) b.imm = 32'($signed($urandom_range(4095)) - 2048);
    else if (m == 2) b.imm = $urandom & 32'hFFFFFFFE;
    else             b.imm = $urandom_range(40);
    return b;
  endfunction

  task automatic drive(input bundle_t b, input logic v);
    bus.in_valid  = v;
    bus.in_type   = b.typ;
    bus.in_opcode = b.op;
    bus.in_rd     = b.rd;
    bus.in_funct3 = b.f3;
    bus.in_rs1    = b.rs1;
    bus.in_rs2    = b.rs2;
    bus.in_funct7 = b.f7;
    bus.in_imm    = b.imm;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    drive(v.b, 1'b1);
    bus.out_ready = 1'b1;
    #1;
    chk({v.name, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({v.name, " early valid"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({v.name, " out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({v.name, " instr"}, 64'(bus.out_instr), 64'(v.instr));
    chk({v.name, " err"}, 64'(bus.out_err), 64'(v.err));
  endtask

  // Streams items with scoreboard; stall window or random out_ready
  task automatic run_stream(input bundle_t items[$], input int st_lo,
      input int st_hi, input bit rnd, output bit saw_block);
    logic [32:0] exp[$];
    logic [32:0] prev;
    bit          hold;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; hold = 0; prev = '0;
    saw_block = 0;
    while (got < items.size() && cyc < 5000) begin
      if (sent < items.size() && (!rnd || $urandom_range(3) != 0))
        drive(items[sent], 1'b1);
      else
        bus.in_valid = 1'b0;
      if (rnd) bus.out_ready = $urandom_range(2) != 0;
      else     bus.out_ready = !(cyc >= st_lo && cyc <= st_hi);
      #1;
      if (hold) begin
        chk("held valid", 64'(bus.out_valid), 64'd1);
        chk("held word", 64'({bus.out_err, bus.out_instr}), 64'(prev));
      end
      if (bus.in_valid && !bus.in_ready) saw_block = 1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp.size() == 0) begin
          n_run++; n_fail++;
          $display("FAIL spurious word: got 0x%08h expected none",
                   bus.out_instr);
        end else begin
          chk("stream word", 64'({bus.out_err, bus.out_instr}),
              64'(exp.pop_front()));
        end
        got++;
      end
      hold = bus.out_valid && !bus.out_ready;
      prev = {bus.out_err, bus.out_instr};
      if (bus.in_valid && bus.in_ready) begin
        exp.push_back(ref_enc(items[sent]));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (got < items.size()) begin
      n_run++; n_fail++;
      $display("FAIL stream timeout: got %0d words expected %0d",
               got, items.size());
    end
  endtask

  initial begin
    vec_t    vecs[$];
    bundle_t items[$];
    bit      blk;

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    do_reset();
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst out_err", 64'(bus.out_err), 64'd0);
    chk("rst enc_count", 64'(enc_count), 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);

    vecs.push_back('{"add", mk(1, 7'h33, 3, 0, 1, 2, 0, 0),
                     32'h002081B3, 1'b0});
    vecs.push_back('{"addi -1", mk(2, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF),
                     32'hFFF00093, 1'b0});
    vecs.push_back('{"addi 0x800", mk(2, 7'h13, 1, 0, 0, 0, 0, 32'h800),
                     32'h80000093, RANGE_EN});
    vecs.push_back('{"beq 8", mk(4, 7'h63, 0, 0, 1, 2, 0, 8),
                     32'h00208463, 1'b0});
    vecs.push_back('{"beq -4", mk(4, 7'h63, 0, 0, 1, 2, 0, 32'hFFFFFFFC),
                     32'hFE208EE3, 1'b0});
    vecs.push_back('{"beq 7", mk(4, 7'h63, 0, 0, 1, 2, 0, 7),
                     32'h00208363, 1'b1});
    vecs.push_back('{"jal 0x800", mk(6, 7'h6F, 1, 0, 0, 0, 0, 32'h800),
                     32'h001000EF, 1'b0});
    vecs.push_back('{"jal 7", mk(6, 7'h6F, 1, 0, 0, 0, 0, 7),
                     32'h006000EF, 1'b1});
    vecs.push_back('{"lui", mk(5, 7'h37, 5, 3, 7, 9, 5, 32'h12345000),
                     32'h123452B7, 1'b0});
    vecs.push_back('{"type0", mk(0, 7'h33, 5, 3, 7, 9, 5, 32'h55),
                     32'h00000000, 1'b1});
    vecs.push_back('{"srai", mk(2, 7'h13, 1, 5, 2, 0, 7'h20, 3),
                     32'h40315093, 1'b0});
    vecs.push_back('{"sw", mk(3, 7'h23, 0, 2, 1, 2, 0, 8),
                     32'h0020A423, 1'b0});
    vecs.push_back('{"ecall", mk(7, 7'h73, 0, 0, 0, 0, 0, 0),
                     32'h00000073, 1'b0});
    do_reset();
    foreach (vecs[k]) apply_vec(vecs[k]);
    @(posedge clk);
    #1;
    chk("vec enc_count", 64'(enc_count), 64'(vecs.size()));
    chk("vec drained", 64'(bus.out_valid), 64'd0);

    do_reset();
    items.delete();
    for (int k = 0; k < 6; k++)
      items.push_back(mk(1, 7'h33, 5'(k + 1), 3'(k), 5'(k), 5'(k + 2),
                         7'(k), 0));
    run_stream(items, 3, 5, 1'b0, blk);
    chk("bp in_ready fell", 64'(blk), 64'd1);
    chk("bp enc_count", 64'(enc_count), 64'd6);

    do_reset();
    bus.out_ready = 1'b0;
    drive(mk(5, 7'h37, 1, 0, 0, 0, 0, 32'h1000), 1'b1);
    @(posedge clk);
    #1;
    drive(mk(5, 7'h37, 2, 0, 0, 0, 0, 32'h2000), 1'b1);
    @(posedge clk);
    #1;
    chk("full out_valid", 64'(bus.out_valid), 64'd1);
    chk("full in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid-rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid-rst enc_count", 64'(enc_count), 64'd0);
    chk("mid-rst in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("no stale word", 64'(bus.out_valid), 64'd0);
    end

    do_reset();
    items.delete();
    for (int k = 0; k < 300; k++) items.push_back(rand_bundle());
    run_stream(items, 0, -1, 1'b1, blk);
    chk("rand enc_count", 64'(enc_count), 64'd300);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
